// File: rtl/cnt_pkg.sv
// Shared types and constants for the prescaled sequence counter.
package cnt_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } cnt_state_e;

    localparam logic DirUp   = 1'b0;
    localparam logic DirDown = 1'b1;

endpackage

// File: rtl/prescaled_seq_counter_if.sv
// Control/status bundle between panel logic (master) and the sequence counter (slave).
interface prescaled_seq_counter_if #(
    parameter int unsigned CNT_W = 8
) ();

    logic             start;
    logic             abort;
    logic             dir_down;
    logic             reload;
    logic [CNT_W-1:0] limit;
    logic             busy;
    logic             finish;
    logic             done_pulse;
    logic             wrap_pulse;
    logic             tick;
    logic [CNT_W-1:0] cnt;

    modport master (
        output start, abort, dir_down, reload, limit,
        input  busy, finish, done_pulse, wrap_pulse, tick, cnt
    );

    modport slave (
        input  start, abort, dir_down, reload, limit,
        output busy, finish, done_pulse, wrap_pulse, tick, cnt
    );

endinterface

// File: rtl/cnt_tick_gen.sv
// Prescaler: registered one-cycle tick every DIV_NUM enabled cycles.
module cnt_tick_gen #(
    parameter int unsigned DIV_NUM = 10_000_000,
    parameter int unsigned DIV_W   = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    if (DIV_NUM == 0 || (64'd1 << DIV_W) < 64'(DIV_NUM)) begin : g_div_check
        $error("DIV_W too narrow for DIV_NUM (or DIV_NUM is zero)");
    end

    localparam logic [DIV_W-1:0] Last = DIV_W'(DIV_NUM - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;

    // en/clr describe the coming cycle, so tick_q lines up with div_q == Last.
    always_comb begin
        div_d = '0;
        if (en && !clr) begin
            div_d = (div_q == Last) ? '0 : div_q + DIV_W'(1);
        end
        tick_d = en && (div_d == Last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/prescaled_seq_counter.sv
// Start-triggered up/down sequence counter with prescaled stepping, auto-reload and abort.
module prescaled_seq_counter
    import cnt_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DIV_NUM = 10_000_000,
    parameter int unsigned DIV_W   = 24
) (
    input logic                   clk,
    input logic                   rst,
    prescaled_seq_counter_if.slave bus
);

    if (CNT_W < 2) begin : g_cnt_w_check
        $error("CNT_W must be at least 2");
    end

    cnt_state_e       state_q, state_d;
    logic             start_s1_q, start_s2_q;
    logic             start_tg;
    logic [CNT_W-1:0] lim_q, lim_d;
    logic             dir_q, dir_d;
    logic             rel_q, rel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             finish_q, finish_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;
    logic             at_term;
    logic             tick;

    cnt_tick_gen #(
        .DIV_NUM (DIV_NUM),
        .DIV_W   (DIV_W)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state_d == StRun),
        .clr  (state_q != StRun),
        .tick (tick)
    );

    assign start_tg = start_s1_q & ~start_s2_q;
    assign at_term  = (dir_q == DirDown) ? (cnt_q == '0) : (cnt_q == lim_q);

    always_comb begin
        state_d  = state_q;
        lim_d    = lim_q;
        dir_d    = dir_q;
        rel_d    = rel_q;
        cnt_d    = cnt_q;
        finish_d = finish_q;
        done_d   = 1'b0;
        wrap_d   = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                // Abort in the same cycle swallows the start edge.
                if (start_tg && !bus.abort) begin
                    lim_d = bus.limit;
                    dir_d = bus.dir_down;
                    rel_d = bus.reload;
                    if (bus.limit == '0) begin
                        state_d  = StDone;
                        finish_d = 1'b1;
                        done_d   = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        state_d  = StRun;
                        finish_d = 1'b0;
                        cnt_d    = (bus.dir_down == DirDown) ? bus.limit : '0;
                    end
                end
            end
            StRun: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (tick) begin
                    if (!at_term) begin
                        cnt_d = (dir_q == DirDown) ? cnt_q - CNT_W'(1) : cnt_q + CNT_W'(1);
                    end else if (rel_q) begin
                        cnt_d  = (dir_q == DirDown) ? lim_q : '0;
                        wrap_d = 1'b1;
                    end else begin
                        state_d  = StDone;
                        finish_d = 1'b1;
                        done_d   = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StRun);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            start_s1_q <= 1'b0;
            start_s2_q <= 1'b0;
            lim_q      <= '0;
            dir_q      <= 1'b0;
            rel_q      <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            finish_q   <= 1'b0;
            done_q     <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_s1_q <= bus.start;
            start_s2_q <= start_s1_q;
            lim_q      <= lim_d;
            dir_q      <= dir_d;
            rel_q      <= rel_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            finish_q   <= finish_d;
            done_q     <= done_d;
            wrap_q     <= wrap_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.finish     = finish_q;
    assign bus.done_pulse = done_q;
    assign bus.wrap_pulse = wrap_q;
    assign bus.tick       = tick;
    assign bus.cnt        = cnt_q;

endmodule
